// File: rtl/nor_wb_arbiter.sv
// nor_wb_arbiter
// Two-master pipelined Wishbone arbiter in front of the NOR flash controller.
// Master 0 is the QSPI control FSM and master 1 is a second on-chip requester
// (scan/scrub sequencer). Whole cycles (cyc high to cyc low) are granted in
// round-robin order. Only the current owner is connected to the slave. A
// cycle that waits too long for a response is aborted, so a hung NOR
// operation cannot lock out the other master.
//
// Ports:
//   clk_i, reset_ni          clock (rising edge) and asynchronous active-low reset
//   mN_cyc/stb/we/adr/dat_i  master N request (N = 0, 1)
//   mN_ack/err/stall_o       master N responses (idle pattern: stall=1)
//   mN_dat_o                 read data; this is s_dat_i for both masters, qualified by ack
//   s_cyc/stb/we/adr/dat_o   request towards the NOR controller
//   s_ack/err/stall/dat_i    responses from the NOR controller
//   grant_o                  one-hot current owner (00 = none)
//   timeout_o                one-cycle pulse when a cycle is aborted
module nor_wb_arbiter #(
  parameter int DATABITS       = 16,
  parameter int TOBITS         = 32,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                clk_i,
  input  logic                reset_ni,
  input  logic                m0_cyc_i,
  input  logic                m0_stb_i,
  input  logic                m0_we_i,
  input  logic [31:0]         m0_adr_i,
  input  logic [DATABITS-1:0] m0_dat_i,
  output logic                m0_ack_o,
  output logic                m0_err_o,
  output logic                m0_stall_o,
  output logic [DATABITS-1:0] m0_dat_o,
  input  logic                m1_cyc_i,
  input  logic                m1_stb_i,
  input  logic                m1_we_i,
  input  logic [31:0]         m1_adr_i,
  input  logic [DATABITS-1:0] m1_dat_i,
  output logic                m1_ack_o,
  output logic                m1_err_o,
  output logic                m1_stall_o,
  output logic [DATABITS-1:0] m1_dat_o,
  output logic                s_cyc_o,
  output logic                s_stb_o,
  output logic                s_we_o,
  output logic [31:0]         s_adr_o,
  output logic [DATABITS-1:0] s_dat_o,
  input  logic                s_ack_i,
  input  logic                s_err_i,
  input  logic                s_stall_i,
  input  logic [DATABITS-1:0] s_dat_i,
  output logic [1:0]          grant_o,
  output logic                timeout_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN0  = 2'd1,
    OWN1  = 2'd2,
    ABORT = 2'd3
  } state_t;

  localparam logic [TOBITS-1:0] TO_VAL  = TOBITS'(TIMEOUT_CYCLES);
  localparam bit                TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [TOBITS-1:0] CNT_MAX = '1;

  state_t            state, next_state;
  logic              last_q, next_last;        // index of the master granted most recently
  logic              abort_owner, next_abort_owner;
  logic [TOBITS-1:0] cnt, next_cnt;
  logic              owned;
  logic              own_cyc;
  logic              resp;
  logic              to_hit;

  // Read data is broadcast; a master only trusts it while its ack is high.
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  assign owned   = (state == OWN0) || (state == OWN1);
  assign own_cyc = (state == OWN1) ? m1_cyc_i : m0_cyc_i;
  assign resp    = s_ack_i | s_err_i;
  // A slave response or the owner releasing the bus in the match cycle takes
  // priority over the abort.
  assign to_hit  = owned && TO_EN && own_cyc && !resp && (cnt == TO_VAL);

  // State, round-robin pointer, abort owner and timeout counter registers.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state       <= IDLE;
      last_q      <= 1'b1;
      abort_owner <= 1'b0;
      cnt         <= '0;
    end else begin
      state       <= next_state;
      last_q      <= next_last;
      abort_owner <= next_abort_owner;
      cnt         <= next_cnt;
    end
  end

  // Next-state logic: arbitration, release, timeout abort and counter update.
  always_comb begin
    next_state       = state;
    next_last        = last_q;
    next_abort_owner = abort_owner;
    next_cnt         = cnt;
    case (state)
      IDLE: begin
        next_cnt = '0;
        if (m0_cyc_i && m1_cyc_i) begin
          // Both requesting: serve the one not served last.
          if (last_q) begin
            next_state = OWN0;
            next_last  = 1'b0;
          end else begin
            next_state = OWN1;
            next_last  = 1'b1;
          end
        end else if (m0_cyc_i) begin
          next_state = OWN0;
          next_last  = 1'b0;
        end else if (m1_cyc_i) begin
          next_state = OWN1;
          next_last  = 1'b1;
        end else begin
          next_state = IDLE;
        end
      end
      OWN0, OWN1: begin
        if (!own_cyc) begin
          next_state = IDLE;
          next_cnt   = '0;
        end else if (to_hit) begin
          next_state       = ABORT;
          next_abort_owner = (state == OWN1);
          next_cnt         = '0;
        end else if (resp) begin
          next_cnt = '0;
        end else if (cnt != CNT_MAX) begin
          next_cnt = cnt + TOBITS'(1);
        end else begin
          next_cnt = cnt;
        end
      end
      ABORT: begin
        next_cnt = '0;
        // Wait for the aborted master to give up its cycle.
        if (!(abort_owner ? m1_cyc_i : m0_cyc_i)) begin
          next_state = IDLE;
        end else begin
          next_state = ABORT;
        end
      end
      default: begin
        next_state = IDLE;
        next_cnt   = '0;
      end
    endcase
  end

  // Output routing: the owner is wired straight through, everyone else sees idle.
  always_comb begin
    s_cyc_o    = 1'b0;
    s_stb_o    = 1'b0;
    s_we_o     = 1'b0;
    s_adr_o    = 32'h0000_0000;
    s_dat_o    = '0;
    m0_ack_o   = 1'b0;
    m0_err_o   = 1'b0;
    m0_stall_o = 1'b1;
    m1_ack_o   = 1'b0;
    m1_err_o   = 1'b0;
    m1_stall_o = 1'b1;
    grant_o    = 2'b00;
    timeout_o  = 1'b0;
    case (state)
      OWN0: begin
        s_cyc_o    = m0_cyc_i;
        s_stb_o    = m0_stb_i;
        s_we_o     = m0_we_i;
        s_adr_o    = m0_adr_i;
        s_dat_o    = m0_dat_i;
        m0_ack_o   = s_ack_i;
        m0_err_o   = s_err_i | to_hit;
        m0_stall_o = s_stall_i;
        grant_o    = 2'b01;
        timeout_o  = to_hit;
      end
      OWN1: begin
        s_cyc_o    = m1_cyc_i;
        s_stb_o    = m1_stb_i;
        s_we_o     = m1_we_i;
        s_adr_o    = m1_adr_i;
        s_dat_o    = m1_dat_i;
        m1_ack_o   = s_ack_i;
        m1_err_o   = s_err_i | to_hit;
        m1_stall_o = s_stall_i;
        grant_o    = 2'b10;
        timeout_o  = to_hit;
      end
      default: begin
        grant_o = 2'b00;
      end
    endcase
  end

endmodule
